// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix lines and debounced key output bundle
interface keypad_scan_if;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x3 keypad column scanner with debounce and one-shot key strobe
module keypad_scan #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scan_en,
    keypad_scan_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] div_cnt;
    logic [1:0]    col_idx;
    logic          idle;
    logic [11:0]   frame;
    logic          eval_pend;
    logic          col_end;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt, cand, cand_nxt;
    logic          accept;
    logic [3:0]    accept_code;
    logic [3:0]    key_code_r;
    logic          key_valid_r;

    logic [3:0]    nbits;
    logic [3:0]    hit_idx;
    logic [3:0]    hit_key;
    logic          cls_none, cls_single;

    function automatic logic [3:0] key_of(input logic [3:0] idx);
        case (idx)
            4'd9:    key_of = 4'd10;
            4'd10:   key_of = 4'd0;
            4'd11:   key_of = 4'd11;
            default: key_of = idx + 4'd1;
        endcase
    endfunction

    assign col_end = (div_cnt == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
        end else begin
            row_s1 <= kp.row_n;
            row_s2 <= row_s1;
        end
    end

    // After a re-enable, idle holds div_cnt at 0 for one edge so col0 gets a full slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            col_idx   <= 2'd0;
            idle      <= 1'b0;
            frame     <= '0;
            eval_pend <= 1'b0;
        end else if (!scan_en) begin
            div_cnt   <= '0;
            col_idx   <= 2'd0;
            idle      <= 1'b1;
            frame     <= '0;
            eval_pend <= 1'b0;
        end else begin
            idle      <= 1'b0;
            eval_pend <= 1'b0;
            if (!idle) begin
                if (col_end) begin
                    div_cnt <= '0;
                    for (int r = 0; r < 4; r++)
                        frame[4'(r * 3) + 4'(col_idx)] <= ~row_s2[r];
                    col_idx   <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
                    eval_pend <= (col_idx == 2'd2);
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        nbits   = 4'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (frame[i]) begin
                nbits   = nbits + 4'd1;
                hit_idx = 4'(i);
            end
        end
        hit_key    = key_of(hit_idx);
        cls_none   = (nbits == 4'd0);
        cls_single = (nbits == 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            cand  <= 4'd0;
        end else if (!scan_en) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cand_nxt    = cand;
        accept      = 1'b0;
        accept_code = cand;
        if (eval_pend) begin
            case (state)
                S_IDLE: begin
                    if (cls_single) begin
                        cand_nxt = hit_key;
                        cnt_nxt  = 4'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept      = 1'b1;
                            accept_code = hit_key;
                            state_nxt   = S_HELD;
                        end else begin
                            state_nxt = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (cls_single && hit_key == cand) begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
                            accept    = 1'b1;
                            state_nxt = S_HELD;
                        end
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
                S_HELD: begin
                    if (cls_none) begin
                        cnt_nxt   = 4'd1;
                        state_nxt = (DEBOUNCE_SCANS == 1) ? S_IDLE : S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (cls_none) begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = 4'd0;
                        end
                    end else begin
                        state_nxt = S_HELD;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
        end else if (!scan_en) begin
            key_valid_r <= 1'b0;
        end else begin
            key_valid_r <= accept;
            if (accept)
                key_code_r <= accept_code;
        end
    end

    assign kp.col_n     = idle ? 3'b111 : ~(3'b001 << col_idx);
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_held  = (state == S_HELD) || (state == S_RELEASE);
endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - scoreboard bench for keypad_scan with a modelled key matrix
module tb_keypad_scan;
    localparam int SD   = 4;
    localparam int DS   = 3;
    localparam int SCAN = 3 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en = 1'b0;
    logic [11:0] pressed = '0;
    logic [3:0]  rn;

    int errors = 0;
    int checks = 0;
    int strobes = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_code;
    logic       prev_valid = 1'b0;

    keypad_scan_if kif();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scan_en(scan_en),
        .kp     (kif)
    );

    always #5 clk = ~clk;

    // A row reads low when any pressed key on it sits in a driven column.
    always_comb begin
        rn = 4'b1111;
        for (int r = 0; r < 4; r++)
            rn[r] = ~|(pressed[r*3 +: 3] & ~kif.col_n);
    end
    assign kif.row_n = rn;

    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: code=%0d, required no strobe", kif.key_code);
            end else begin
                exp_code = exp_q.pop_front();
                if (kif.key_code !== exp_code) begin
                    errors++;
                    $display("FAIL strobe_code: got %0d, required %0d", kif.key_code, exp_code);
                end
            end
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL strobe_width: key_valid high 2 cycles, required 1");
            end
        end
        prev_valid = (kif.key_valid === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_strobe(input string name, input int budget);
        int s0;
        int k;
        s0 = strobes;
        k = 0;
        while (strobes == s0 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (strobes == s0) begin
            errors++;
            $display("FAIL %s: strobes=%0d after %0d cycles, required >%0d", name, strobes, budget, s0);
        end
    endtask

    task automatic expect_quiet(input string name, input int n);
        int s0;
        s0 = strobes;
        tick(n);
        checks++;
        if (strobes !== s0) begin
            errors++;
            $display("FAIL %s: strobes=%0d, required %0d", name, strobes, s0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        scan_en = 1'b1;
        pressed = 12'(1 << 4);
        tick(3);
        checks++;
        if (kif.col_n !== 3'b110) begin errors++; $display("FAIL reset_col: got %b, required 110", kif.col_n); end
        checks++;
        if (kif.key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d, required 0", kif.key_code); end
        checks++;
        if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", kif.key_valid); end
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b, required 0", kif.key_held); end
        rst_n = 1'b1;
    endtask

    task automatic test_press_hold;
        exp_q.push_back(4'd5);
        wait_strobe("press5", 100);
        tick(1);
        checks++;
        if (kif.key_held !== 1'b1) begin errors++; $display("FAIL press5_held: got %b, required 1", kif.key_held); end
        checks++;
        if (kif.key_code !== 4'd5) begin errors++; $display("FAIL press5_code: got %0d, required 5", kif.key_code); end
        expect_quiet("hold5_no_repeat", 5 * SCAN);
    endtask

    task automatic test_release_repress;
        pressed = '0;
        tick(2 * SCAN);
        pressed = 12'(1 << 4);
        expect_quiet("repress_no_strobe", 3 * SCAN);
        checks++;
        if (kif.key_held !== 1'b1) begin errors++; $display("FAIL repress_held: got %b, required 1", kif.key_held); end
        pressed = '0;
        tick(5 * SCAN);
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL released_held: got %b, required 0", kif.key_held); end
        pressed = 12'(1 << 11);
        exp_q.push_back(4'd11);
        wait_strobe("hash", 6 * SCAN);
    endtask

    task automatic test_bounce;
        pressed = '0;
        tick(5 * SCAN);
        exp_q.push_back(4'd7);
        for (int i = 0; i < 5; i++) begin
            pressed = (i % 2 == 0) ? 12'(1 << 6) : 12'd0;
            expect_quiet("bounce7", SCAN);
        end
        pressed = 12'(1 << 6);
        wait_strobe("stable7", 6 * SCAN);
    endtask

    task automatic test_multi;
        pressed = '0;
        tick(5 * SCAN);
        pressed = 12'((1 << 0) | (1 << 2));
        expect_quiet("multi_no_strobe", 6 * SCAN);
        checks++;
        if (kif.key_code !== 4'd7) begin errors++; $display("FAIL multi_code: got %0d, required 7", kif.key_code); end
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL multi_held: got %b, required 0", kif.key_held); end
        pressed = '0;
        tick(2 * SCAN);
    endtask

    task automatic test_scan_en_drop;
        int k;
        int bad;
        k = 0;
        while (kif.col_n !== 3'b011 && k < 4 * SCAN) begin tick(1); k++; end
        while (kif.col_n !== 3'b110 && k < 8 * SCAN) begin tick(1); k++; end
        checks++;
        if (kif.col_n !== 3'b110) begin errors++; $display("FAIL align_col: got %b, required 110", kif.col_n); end
        pressed = 12'(1 << 1);
        tick(2 * SCAN + 4);
        scan_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            expect_quiet("drop_no_strobe", 1);
            if (kif.col_n !== 3'b111) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL drop_col: %0d cycles with col_n!=111, required 0", bad); end
        checks++;
        if (kif.key_code !== 4'd7) begin errors++; $display("FAIL drop_code: got %0d, required 7", kif.key_code); end
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL drop_held: got %b, required 0", kif.key_held); end
        scan_en = 1'b1;
        exp_q.push_back(4'd2);
        expect_quiet("reenable_fresh_debounce", 30);
        wait_strobe("reenable_strobe", 20);
    endtask

    task automatic test_reset_mid;
        pressed = '0;
        tick(5 * SCAN);
        pressed = 12'(1 << 8);
        exp_q.push_back(4'd9);
        wait_strobe("press9", 6 * SCAN);
        tick(1);
        checks++;
        if (kif.key_held !== 1'b1) begin errors++; $display("FAIL held9: got %b, required 1", kif.key_held); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (kif.key_code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d, required 0", kif.key_code); end
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL midrst_held: got %b, required 0", kif.key_held); end
        checks++;
        if (kif.col_n !== 3'b110) begin errors++; $display("FAIL midrst_col: got %b, required 110", kif.col_n); end
        tick(3);
        rst_n = 1'b1;
        exp_q.push_back(4'd9);
        expect_quiet("post_reset_debounce", 30);
        wait_strobe("post_reset_strobe", 20);
    endtask

    initial begin
        test_reset();
        test_press_hold();
        test_release_repress();
        test_bounce();
        test_multi();
        test_scan_en_drop();
        test_reset_mid();
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected: %0d strobes outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Upstream digit source for the one-hot stretch stage.
- Drives a 4x3 matrix keypad one column at a time, synchronises and debounces the row returns, and resolves exactly one pressed key.
- Emits one 4-bit key code with a single-cycle valid strobe per debounced press. These outputs connect directly to the stretch stage's digit and enable inputs.

Parameters:
- SCAN_DIV, 16: clock cycles each column stays driven; legal range 4 to 65535.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix scans required to accept a press or a release; legal range 1 to 15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scan_en  in  1  scanning enable; low forces idle
- row_n  in  4  keypad row returns, active-low, asynchronous to clk
- col_n  out  3  column drives, active-low, exactly one low while scanning
- key_code  out  4  code of last accepted key
- key_valid  out  1  one-cycle strobe, new key_code accepted
- key_held  out  1  high while the accepted key is still considered pressed

Behaviour:
- Reset: asynchronous assert, synchronous deassert path via clk. Values during reset:
  - col_n=3'b110, key_code=0, key_valid=0, key_held=0
  - FSM in IDLE, all counters 0, synchroniser flops 4'b1111
- Synchroniser: row_n passes through a 2-flop synchroniser before use. Because SCAN_DIV>=4, sampled rows are settled.
- Column sequencing:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - On the edge where div_cnt==SCAN_DIV-1:
    - the synchronised rows are captured into frame bits for the current column (pressed = row low);
    - the column advances col0 -> col1 -> col2 -> col0 (col_n 110 -> 101 -> 011).
  - One scan = 3*SCAN_DIV cycles.
- Frame evaluation:
  - Occurs on the edge one cycle after the col2 capture edge.
  - Frame class: NONE (0 bits set), SINGLE (1 bit set), MULTI (2 or more bits set).
- Key map (row r, col c):
  - row0: 1,2,3
  - row1: 4,5,6
  - row2: 7,8,9
  - row3: * = 4'd10, 0 = 4'd0, # = 4'd11
- FSM, with transitions taken only at frame evaluation:
  - IDLE:
    - SINGLE: cand=key, cnt=1; if DEBOUNCE_SCANS==1 then accept, else go to DEBOUNCE.
    - NONE or MULTI: stay.
  - DEBOUNCE:
    - SINGLE with key==cand: cnt+1; when cnt reaches DEBOUNCE_SCANS, accept.
    - Any other class or key: go to IDLE, cnt=0.
  - Accept: key_code<=cand and key_valid=1 in the next cycle only; go to HELD.
  - HELD:
    - NONE: cnt=1; if DEBOUNCE_SCANS==1 go to IDLE, else go to RELEASE.
    - SINGLE or MULTI: stay (no auto-repeat).
  - RELEASE:
    - NONE: cnt+1; when cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - Non-NONE: go back to HELD (no new strobe).
- Output timing:
  - key_valid rises one cycle after the accepting evaluation edge and is high for exactly 1 cycle.
  - key_code changes only at accept and holds between accepts.
- key_held is high in HELD and RELEASE, low otherwise.
- scan_en low, sampled synchronously at any time:
  - col_n=3'b111, div_cnt=0, column index=col0, frame cleared, FSM=IDLE, cnt=0, key_held=0;
  - key_code holds; key_valid=0 (a pending strobe is suppressed).
  - Re-enable restarts at col0 with a fresh frame.
- Reset mid-operation: all state returns to reset values immediately. No strobe is emitted.
- Codes 10 and 11 are emitted normally; the downstream stage ignores them.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_SCANS=3, key '5' (row1, col1) held stable from cycle 0 -> exactly one key_valid pulse, key_code=5, key_held=1; no further strobes while held.
- Key '7' bounces, alternating pressed/none across scans for 5 scans, then is stable -> no strobe during bouncing; a single strobe with code 7 after 3 consecutive clean scans.
- Keys '1' and '3' pressed together for 6 scans -> no strobe; key_code keeps its prior value.
- After '5' is accepted, release for 2 scans and re-press -> no new strobe (RELEASE returns to HELD). Release for 3 or more scans, then press '#' -> strobe with key_code=11.
- scan_en dropped during DEBOUNCE, after 2 matching scans, for 10 cycles:
  - col_n=111 during the drop, no strobe;
  - after re-enable, 3 full matching scans are needed before the strobe.
- rst_n asserted while in HELD with key_code=9 -> immediately key_code=0, key_held=0, col_n=110. After release of reset with the key still pressed, a fresh debounce (3 scans) produces a strobe with code 9.
